// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared constants for the FTDI TX arbiter: FSM encodings, header defaults
// and the header byte builder.
package ftdi_pkg;

  localparam logic [1:0] ST_ARB_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARB_HEADER = 2'd1;
  localparam logic [1:0] ST_ARB_DATA   = 2'd2;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
  localparam logic [3:0] HDR_ID_MASK      = 4'hF;

  // Channel header byte: base with the source id OR-ed into the low nibble.
  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [3:0] id);
    return base | {4'h0, id & HDR_ID_MASK};
  endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_if.sv
// Producer-side and bridge-side handshake bundle of the TX arbiter.
// master = the arbiter, slave = the producers/bridge environment.
interface ftdi_tx_arbiter_if #(
  parameter int N_SRC = 4
) ();

  logic [N_SRC-1:0]   src_valid;
  logic [N_SRC-1:0]   src_last;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_ready;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_ready;
  logic [3:0]         grant_id;
  logic               busy;

  modport master (
    input  src_valid, src_last, src_data, out_ready,
    output src_ready, out_valid, out_data, grant_id, busy
  );

  modport slave (
    output src_valid, src_last, src_data, out_ready,
    input  src_ready, out_valid, out_data, grant_id, busy
  );

endinterface

// File: rtl/ftdi_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at N. Kept generic so the RX demux can reuse it.
module ftdi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  logic          found;
  logic [SW-1:0] sum;
  logic [IW-1:0] pos;

  // Scan offsets 0..N-1 from the pointer; the smallest offset wins.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      pos = sum[IW-1:0];
      if (!found && req_i[pos]) begin
        found = 1'b1;
        idx_o = pos;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the FTDI bridge TX path.
// Each grant optionally starts with a channel header byte; data bytes are
// passed through combinationally from the granted producer.
module ftdi_tx_arbiter
  import ftdi_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter int         MAX_BURST = 16,
  parameter int         HDR_EN    = 1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
  input logic                clock_in,
  input logic                reset,
  ftdi_tx_arbiter_if.master  bus
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] ID_LAST  = IW'(N_SRC - 1);
  localparam logic [IW-1:0] ID_ONE   = IW'(1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          data_fire;
  logic          burst_end;

  ftdi_rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req_i (bus.src_valid),
    .ptr_i (rr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign sel_valid = bus.src_valid[gnt_q];
  assign sel_last  = bus.src_last[gnt_q];
  assign sel_data  = bus.src_data[{gnt_q, 3'b000} +: 8];

  assign data_fire = (state_q == ST_ARB_DATA) && sel_valid && bus.out_ready;
  // A burst ends on the producer's last byte or when the grant is used up.
  assign burst_end = sel_last || (cnt_q == CNT_LAST);

  assign bus.busy     = (state_q != ST_ARB_IDLE);
  assign bus.grant_id = 4'(gnt_q);

  // Only the granted producer sees the bridge's ready, and only in DATA.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
    assign bus.src_ready[gi] = (state_q == ST_ARB_DATA) && (gnt_q == IW'(gi)) && bus.out_ready;
  end

  // Bridge-facing byte: header in HEADER, pass-through in DATA, zero in IDLE.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    case (state_q)
      ST_ARB_HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr_byte(HDR_BASE, 4'(gnt_q));
      end
      ST_ARB_DATA: begin
        bus.out_valid = sel_valid;
        bus.out_data  = sel_data;
      end
      default: begin
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
      end
    endcase
  end

  // Arbitration, header/data sequencing and burst accounting.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARB_IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = (HDR_EN != 0) ? ST_ARB_HEADER : ST_ARB_DATA;
        end
      end
      ST_ARB_HEADER: begin
        if (bus.out_ready) begin
          state_d = ST_ARB_DATA;
        end
      end
      ST_ARB_DATA: begin
        if (data_fire) begin
          if (burst_end) begin
            state_d = ST_ARB_IDLE;
            rr_d    = (gnt_q == ID_LAST) ? '0 : gnt_q + ID_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_ARB_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: two instances (header on / MAX_BURST=4, header
// off / MAX_BURST=16) compared every cycle against a packet-level model,
// plus literal expected byte streams for the directed scenarios.
module tb_ftdi_tx_arbiter;
  import ftdi_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ftdi_tx_arbiter_if #(.N_SRC(N)) ifa ();
  ftdi_tx_arbiter_if #(.N_SRC(N)) ifb ();

  ftdi_tx_arbiter #(.N_SRC(N), .MAX_BURST(4), .HDR_EN(1), .HDR_BASE(8'hA0)) dut_a (
    .clock_in (clk),
    .reset    (rst),
    .bus      (ifa)
  );

  ftdi_tx_arbiter #(.N_SRC(N), .MAX_BURST(16), .HDR_EN(0), .HDR_BASE(8'hA0)) dut_b (
    .clock_in (clk),
    .reset    (rst),
    .bus      (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  int gap_pct  = 0;
  int stall_pct = 0;

  logic [7:0] qd [2][N][$];
  bit         ql [2][N][$];
  logic [7:0] out_log [2][$];
  logic [7:0] exp_q [$];
  logic [7:0] sent [N][$];
  logic [7:0] recv [N][$];
  int         sr_cnt [2][N];
  logic [N-1:0] fire [2];

  typedef struct {
    bit busy;
    bit hdr;
    int g;
    int cnt;
    int rr;
  } mdl_t;

  mdl_t m [2];
  int max_of [2] = '{4, 16};
  bit hen_of [2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] sv_of(input int d);
    return (d == 0) ? ifa.src_valid : ifb.src_valid;
  endfunction

  function automatic logic ov_of(input int d);
    return (d == 0) ? ifa.out_valid : ifb.out_valid;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? ifa.busy : ifb.busy;
  endfunction

  // Per-cycle comparison against the packet model, then model advance.
  task automatic cmp(input int d, input logic [N-1:0] sv, input logic [N-1:0] sl,
                     input logic [8*N-1:0] sd, input logic ordy, input logic ov,
                     input logic [7:0] od, input logic [N-1:0] sr,
                     input logic [3:0] gid, input logic bsy);
    logic       e_ov;
    logic [7:0] e_od;
    logic [N-1:0] e_sr;
    e_ov = 1'b0;
    e_od = 8'h00;
    e_sr = '0;
    if (m[d].busy && m[d].hdr) begin
      e_ov = 1'b1;
      e_od = 8'hA0 | 8'(m[d].g);
    end else if (m[d].busy) begin
      e_ov = sv[m[d].g];
      e_od = sd[8*m[d].g +: 8];
      e_sr[m[d].g] = ordy;
    end
    if (chk_en) begin
      chk($sformatf("dut%0d out_valid", d), 32'(ov), 32'(e_ov));
      chk($sformatf("dut%0d out_data", d), 32'(od), 32'(e_od));
      chk($sformatf("dut%0d src_ready", d), 32'(sr), 32'(e_sr));
      chk($sformatf("dut%0d busy", d), 32'(bsy), 32'(m[d].busy));
      if (m[d].busy) chk($sformatf("dut%0d grant_id", d), 32'(gid), 32'(m[d].g));
    end
    fire[d] = sr & sv;
    for (int i = 0; i < N; i++) if (sr[i]) sr_cnt[d][i]++;
    if (ov && ordy) out_log[d].push_back(od);
    if (rst) begin
      m[d] = '{busy: 1'b0, hdr: 1'b0, g: 0, cnt: 0, rr: 0};
    end else if (!m[d].busy) begin
      if (sv != '0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m[d].rr + k) % N;
          if (sv[idx]) begin
            m[d].g = idx;
            break;
          end
        end
        m[d].busy = 1'b1;
        m[d].hdr  = hen_of[d];
        m[d].cnt  = 0;
      end
    end else if (m[d].hdr) begin
      if (ordy) m[d].hdr = 1'b0;
    end else if (sv[m[d].g] && ordy) begin
      if (sl[m[d].g] || m[d].cnt == max_of[d] - 1) begin
        m[d].busy = 1'b0;
        m[d].rr   = (m[d].g + 1) % N;
      end else begin
        m[d].cnt++;
      end
    end
  endtask

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    cmp(0, ifa.src_valid, ifa.src_last, ifa.src_data, ifa.out_ready, ifa.out_valid,
        ifa.out_data, ifa.src_ready, ifa.grant_id, ifa.busy);
    cmp(1, ifb.src_valid, ifb.src_last, ifb.src_data, ifb.out_ready, ifb.out_valid,
        ifb.out_data, ifb.src_ready, ifb.grant_id, ifb.busy);
  end

  task automatic drive(input int d);
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] dt;
    logic           r;
    for (int i = 0; i < N; i++) begin
      if (qd[d][i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        v[i] = 1'b1;
        dt[8*i +: 8] = qd[d][i][0];
        l[i] = ql[d][i][0];
      end else begin
        v[i] = 1'b0;
        dt[8*i +: 8] = 8'($urandom);
        l[i] = 1'($urandom);
      end
    end
    r = ($urandom_range(99) >= stall_pct);
    if (d == 0) begin
      ifa.src_valid = v; ifa.src_last = l; ifa.src_data = dt; ifa.out_ready = r;
    end else begin
      ifb.src_valid = v; ifb.src_last = l; ifb.src_data = dt; ifb.out_ready = r;
    end
  endtask

  // Producer models: pop accepted bytes, then offer the next one (with gaps).
  initial begin
    fire[0] = '0;
    fire[1] = '0;
    drive(0);
    drive(1);
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (fire[d][i] && qd[d][i].size() > 0) begin
            void'(qd[d][i].pop_front());
            void'(ql[d][i].pop_front());
          end
        end
        drive(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int d, input int i, input logic [7:0] b, input bit last);
    qd[d][i].push_back(b);
    ql[d][i].push_back(last);
  endtask

  function automatic bit queues_empty(input int d);
    for (int i = 0; i < N; i++) if (qd[d][i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int d, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((!queues_empty(d) || busy_of(d)) && k < budget);
    chk($sformatf("dut%0d drain within budget", d), 32'(k < budget), 32'd1);
    tick();
  endtask

  task automatic lat(input int d, input int exp);
    int rc;
    int oc;
    rc = -1;
    oc = -1;
    for (int k = 0; k < 20; k++) begin
      if (rc < 0 && sv_of(d) != '0) rc = cyc;
      if (oc < 0 && ov_of(d)) oc = cyc;
      if (rc >= 0 && oc >= 0) break;
      tick();
    end
    chk($sformatf("dut%0d request-to-offer latency", d), 32'(oc - rc), 32'(exp));
  endtask

  task automatic expect_log(input int d, input string name);
    int n;
    chk({name, " length"}, 32'(out_log[d].size()), 32'(exp_q.size()));
    n = (out_log[d].size() < exp_q.size()) ? out_log[d].size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s byte %0d", name, k), 32'(out_log[d][k]), 32'(exp_q[k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ch;
    int bad;
    int len;
    logic [7:0] b;

    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    chk("reset busy", 32'(ifa.busy), 32'd0);
    chk("reset out_valid", 32'(ifa.out_valid), 32'd0);
    chk("reset src_ready", 32'(ifa.src_ready), 32'd0);
    chk("reset out_data", 32'(ifa.out_data), 32'h00);
    chk("reset B out_valid", 32'(ifb.out_valid), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single 3-byte packet from src 2
    out_log[0].delete();
    for (int i = 0; i < N; i++) sr_cnt[0][i] = 0;
    push_byte(0, 2, 8'h11, 1'b0);
    push_byte(0, 2, 8'h22, 1'b0);
    push_byte(0, 2, 8'h33, 1'b1);
    lat(0, 1);
    wait_idle(0, 50);
    exp_q = {8'hA2, 8'h11, 8'h22, 8'h33};
    expect_log(0, "single");
    chk("src_ready[2] cycles", 32'(sr_cnt[0][2]), 32'd3);
    $display("txn single: %0d bytes out", out_log[0].size());

    // 2: simultaneous requests from 0 and 1, then 0 and 3 to show the wrap
    out_log[0].delete();
    push_byte(0, 0, 8'h01, 1'b0);
    push_byte(0, 0, 8'h02, 1'b1);
    push_byte(0, 1, 8'h03, 1'b0);
    push_byte(0, 1, 8'h04, 1'b1);
    wait_idle(0, 50);
    push_byte(0, 0, 8'h05, 1'b1);
    push_byte(0, 3, 8'h06, 1'b1);
    wait_idle(0, 50);
    exp_q = {8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04, 8'hA3, 8'h06, 8'hA0, 8'h05};
    expect_log(0, "rr");
    $display("txn rr: %0d bytes out", out_log[0].size());

    // 3: 6-byte packet from src 3 split at MAX_BURST=4
    out_log[0].delete();
    for (int k = 1; k <= 6; k++) push_byte(0, 3, 8'(8'h30 + k), k == 6);
    wait_idle(0, 50);
    exp_q = {8'hA3, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA3, 8'h35, 8'h36};
    expect_log(0, "split");
    $display("txn split: %0d bytes out", out_log[0].size());

    // 4: random packets with producer gaps and bridge backpressure
    out_log[0].delete();
    gap_pct = 30;
    stall_pct = 30;
    for (int i = 0; i < N; i++) begin
      sent[i].delete();
      recv[i].delete();
      for (int p = 0; p < 4; p++) begin
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 159));
          push_byte(0, i, b, k == len - 1);
          sent[i].push_back(b);
        end
      end
    end
    wait_idle(0, 5000);
    gap_pct = 0;
    stall_pct = 0;
    ch = -1;
    foreach (out_log[0][k]) begin
      if (out_log[0][k] >= 8'hA0 && out_log[0][k] <= 8'hA3) ch = int'(out_log[0][k] - 8'hA0);
      else if (ch >= 0) recv[ch].push_back(out_log[0][k]);
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("random src%0d byte count", i), 32'(recv[i].size()), 32'(sent[i].size()));
      bad = 0;
      for (int k = 0; k < sent[i].size() && k < recv[i].size(); k++)
        if (recv[i][k] !== sent[i][k]) bad++;
      chk($sformatf("random src%0d order errors", i), 32'(bad), 32'd0);
      $display("txn random src%0d: sent %0d recv %0d", i, sent[i].size(), recv[i].size());
    end

    // 5: reset during DATA of src 1
    for (int k = 0; k < 6; k++) push_byte(0, 1, 8'(8'h40 + k), k == 5);
    begin
      int k;
      k = 0;
      while (ifa.src_ready[1] !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      chk("reached DATA of src1", 32'(k < 20), 32'd1);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      qd[0][i].delete();
      ql[0][i].delete();
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("post-reset out_valid", 32'(ifa.out_valid), 32'd0);
    chk("post-reset src_ready", 32'(ifa.src_ready), 32'd0);
    chk("post-reset busy", 32'(ifa.busy), 32'd0);
    tick();
    out_log[0].delete();
    push_byte(0, 1, 8'h51, 1'b1);
    push_byte(0, 3, 8'h53, 1'b1);
    wait_idle(0, 50);
    exp_q = {8'hA1, 8'h51, 8'hA3, 8'h53};
    expect_log(0, "after reset");
    $display("txn reset: %0d bytes out", out_log[0].size());

    // 6: no headers, two sources alternating
    out_log[1].delete();
    push_byte(1, 0, 8'hC1, 1'b0);
    push_byte(1, 0, 8'hC2, 1'b1);
    push_byte(1, 1, 8'hD1, 1'b0);
    push_byte(1, 1, 8'hD2, 1'b1);
    lat(1, 1);
    wait_idle(1, 50);
    push_byte(1, 0, 8'hC3, 1'b1);
    push_byte(1, 1, 8'hD3, 1'b1);
    wait_idle(1, 50);
    exp_q = {8'hC1, 8'hC2, 8'hD1, 8'hD2, 8'hC3, 8'hD3};
    expect_log(1, "no header");
    $display("txn no-header: %0d bytes out", out_log[1].size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Shares the single host-bound byte path of the FTDI bridge among `N_SRC` on-chip producers. Round-robin arbitration at packet granularity. Each granted packet is prefixed with a one-byte channel header so the PC can demultiplex the streams. Sits between the producers and the bridge's `from_top_valid` / `from_top_ready` / `from_top_to_tx` inputs.

## Interface
- `N_SRC`, 4: number of producers, 2..16.
- `MAX_BURST`, 16: maximum data bytes per grant, 1..256.
- `HDR_EN`, 1: 1 = emit a header byte per grant; 0 = no header.
- `HDR_BASE`, 8'hA0: header value is `HDR_BASE | id`, with the id in bits [3:0].
- `clock_in`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `src_valid`  in  N_SRC  per-source byte available.
- `src_last`  in  N_SRC  per-source; marks the final byte of a packet.
- `src_data`  in  8*N_SRC  per-source byte; source i occupies [8i+7:8i].
- `src_ready`  out  N_SRC  per-source; byte accepted this cycle.
- `out_valid`  out  1  byte offered to the bridge.
- `out_data`  out  8  byte to the bridge.
- `out_ready`  in  1  bridge accepts the byte this cycle.
- `grant_id`  out  4  currently granted source; valid while `busy` is high.
- `busy`  out  1  high in HEADER or DATA.

## Operation
- A transfer occurs on any rising edge where valid and ready are both high.
- While valid is high and not yet accepted, data must stay stable.
- **IDLE**
  - `out_valid` = 0; all `src_ready` = 0.
  - If any `src_valid` is high, pick the first requester searching upward from `rr_ptr` (wrapping at `N_SRC`). Register it as `grant_id`.
  - Next state is HEADER if `HDR_EN`=1, otherwise DATA.
  - Burst counter is cleared.
- **HEADER**
  - `out_valid` = 1; `out_data` = `HDR_BASE | grant_id`.
  - On transfer, go to DATA.
  - No `src_ready` is asserted during HEADER.
- **DATA** (combinational pass-through of the granted source)
  - `out_valid` = `src_valid[g]`; `out_data` = `src_data[g]`; `src_ready[g]` = `out_ready`. All other `src_ready` bits = 0.
  - Each transfer increments the burst counter.
  - If a transfer has `src_last[g]`=1, or the counter equals `MAX_BURST-1`: go to IDLE, set `rr_ptr` to `(g+1) mod N_SRC`.
- **Boundary conditions**
  - Granted source drops valid mid-packet: stay in DATA with `out_valid`=0. No timeout, no re-arbitration.
  - Packet longer than `MAX_BURST`: split. The remainder competes again in IDLE and gets a fresh header.
  - Requests from other sources during HEADER/DATA are ignored until IDLE.
  - Non-granted `src_valid` may change freely.
  - `src_last` is sampled only on a DATA transfer from the granted source.
  - `reset` mid-packet: the burst is abandoned and no further bytes are sent. The bridge may already hold a partial packet; recovery is the PC's job.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, burst counter 0, `busy`=0, `out_valid`=0, `src_ready`=0. `out_data` = 8'h00 in IDLE.
- Latency: a request seen in IDLE at cycle N gives header `out_valid` at N+1.
  - With `out_ready` held high, the first data byte transfers at N+2.
  - With `HDR_EN`=0, the first data byte is offered at N+1.
- Throughput with `out_ready` held high: one byte per cycle within a grant.
- Grant switch overhead: 1 idle cycle, plus the header byte when `HDR_EN`=1.
- `src_ready` and `out_valid` in DATA are combinational from the inputs. The bridge's registered ready breaks the loop.

## Structure
- Package `ftdi_pkg`:
  - state encodings `ST_ARB_IDLE` / `ST_ARB_HEADER` / `ST_ARB_DATA` (2 bits);
  - default `HDR_BASE`;
  - the header id mask 4'hF.
- Sub-module `ftdi_rr_pick`: combinational round-robin priority picker. Inputs are request vector and pointer; outputs are `any` and index. Reusable for the planned RX demux.
- Burst counter width is `$clog2(MAX_BURST)`, minimum 1 bit.

## Test plan
- Single source, 3-byte packet 11,22,33 from src 2, `out_ready`=1 → out stream A2,11,22,33. `src_ready[2]` high for exactly 3 cycles. `busy` falls after byte 33.
- src 0 and src 1 request in the same cycle, 2-byte packets each → A0,p0,p0,A1,p1,p1. Next src 0 packet is served after src 1 (`rr_ptr` wraps correctly at `N_SRC`).
- `MAX_BURST`=4, src 3 sends 6 bytes with `src_last` only on byte 6 → A3,b1..b4, one idle cycle, A3,b5,b6.
- Random `out_ready` backpressure plus `src_valid` gaps mid-packet → byte order preserved, no duplicates, `out_data` stable while stalled.
- `reset` asserted during the DATA of src 1 → next cycle `out_valid`=0, `src_ready`=0, `rr_ptr`=0. Subsequent request from src 1 gets a new header A1.
- `HDR_EN`=0, two sources alternating → data bytes only. First byte appears 1 cycle after the request.
